ula_mdu: RTL and testbench

Parametrised, registered ALU with an integrated iterative multiply/divide unit and HI/LO registers. It replaces the combinational R-type ALU in the multicycle MIPS datapath and keeps its 4-bit operation encoding for single-cycle ops. A 5th opcode bit selects MULT/MULTU/DIV/DIVU and the HI/LO moves. Multi-cycle operations use a start/busy/done handshake, so the control FSM stalls on `busy`.

---
 rtl/ula_mdu.sv | 222 ++++++++++++++++++++++
 tb/tb_ula_mdu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_mdu.sv
// ula_mdu: registered ALU with iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops complete one clock after start; MULT/MULTU (and DIV/DIVU when
// the ULA_MDU_DIV_EN macro is defined) run IDLE -> CALC -> FIX over WIDTH+1 cycles.
module ula_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic [WIDTH-1:0] result,
  output logic             Zero_flag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic             neg_q, neg_d;     // negate product / quotient in FIX
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
`ifdef ULA_MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             rneg_q, rneg_d;   // remainder takes dividend sign
  logic             dz_q, dz_d;       // divisor was zero
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  // State and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef ULA_MDU_DIV_EN
      is_div_q   <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ULA_MDU_DIV_EN
      is_div_q   <= is_div_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  // Next-state, single-cycle ALU, and one-bit-per-cycle mul/div iteration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef ULA_MDU_DIV_EN
    is_div_d   = is_div_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    div_diff   = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]} - opnd_q;
    div_ge     = {acc_q, mq_q[WIDTH-1]} >= {1'b0, opnd_q};
`endif

    // OP[0]=0 selects the signed variant of MULT/DIV
    sa       = ~OP[0] & In1[WIDTH-1];
    sb       = ~OP[0] & In2[WIDTH-1];
    mag_a    = sa ? ('0 - In1) : In1;
    mag_b    = sb ? ('0 - In2) : In2;
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix = neg_q ? ('0 - {acc_q, mq_q}) : {acc_q, mq_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          if (!OP[4]) begin
            case (OP[3:0])
              4'b0000: result_d = In1 + In2;
              4'b0001: result_d = In1 - In2;
              4'b0011: result_d = In1 & In2;
              4'b0100: result_d = ~(In1 | In2);
              4'b0101: result_d = In1 | In2;
              4'b0110: result_d = In1 ^ In2;
              4'b0111: result_d = In2 << In1[SHW-1:0];
              4'b1000: result_d = In1 << In2[SHW-1:0];
              4'b1001: result_d = In2 >> In1[SHW-1:0];
              4'b1010: result_d = In1 >> In2[SHW-1:0];
              4'b1110: result_d = {{(WIDTH-1){1'b0}}, $signed(In1) < $signed(In2)};
              4'b1111: result_d = {{(WIDTH-1){1'b0}}, In1 < In2};
              default: result_d = '0;
            endcase
          end else begin
            case (OP[3:0])
              4'b0000, 4'b0001: begin
                acc_d   = '0;
                mq_d    = mag_a;
                opnd_d  = mag_b;
                neg_d   = sa ^ sb;
                cnt_d   = '1;
                state_d = S_CALC;
                done_d  = 1'b0;
`ifdef ULA_MDU_DIV_EN
                is_div_d = 1'b0;
`endif
              end
              4'b0010, 4'b0011: begin
`ifdef ULA_MDU_DIV_EN
                acc_d    = '0;
                mq_d     = mag_a;
                opnd_d   = mag_b;
                neg_d    = sa ^ sb;
                rneg_d   = sa;
                dz_d     = (In2 == '0);
                is_div_d = 1'b1;
                cnt_d    = '1;
                state_d  = S_CALC;
                done_d   = 1'b0;
`endif
              end
              4'b0100: result_d = hi_q;
              4'b0101: result_d = lo_q;
              4'b0110: hi_d = In1;
              4'b0111: lo_d = In1;
              default: result_d = '0;
            endcase
          end
        end
      end
      S_CALC: begin
        // Shift-add: conditional add into the high half, then shift the pair right
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef ULA_MDU_DIV_EN
        // Restoring divide: a zero divisor always "fits", so the dividend
        // magnitude ends up in acc, which FIX sign-restores into HI
        if (is_div_q) begin
          acc_d = div_ge ? div_diff : {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
          mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end
`endif
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = prod_fix;
`ifdef ULA_MDU_DIV_EN
        if (is_div_q) begin
          lo_d       = dz_q ? '1 : (neg_q ? ('0 - mq_q) : mq_q);
          hi_d       = rneg_q ? ('0 - acc_q) : acc_q;
          div_zero_d = dz_q;
        end
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  assign result    = result_q;
  assign Zero_flag = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
`ifdef ULA_MDU_DIV_EN
  assign div_zero  = div_zero_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_ula_mdu.sv
// tb_ula_mdu: randomized self-checking bench for ula_mdu against an arithmetic
// reference model; DIV expectations follow the ULA_MDU_DIV_EN macro.
module tb_ula_mdu;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   OP    = '0;
  logic [W-1:0] In1   = '0;
  logic [W-1:0] In2   = '0;
  logic [W-1:0] result, hi, lo;
  logic         Zero_flag, busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_hi     = '0;
  logic [W-1:0] m_lo     = '0;
  logic         m_dz     = 1'b0;

  always #5 clk = ~clk;

  ula_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .OP(OP), .In1(In1), .In2(In2),
    .result(result), .Zero_flag(Zero_flag), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_result"}, result, m_result);
    check({tag, "_zero"}, Zero_flag, m_result == '0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    check({tag, "_divzero"}, div_zero, m_dz);
  endtask

  function automatic void model_single(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      5'd0:  m_result = a + b;
      5'd1:  m_result = a - b;
      5'd3:  m_result = a & b;
      5'd4:  m_result = ~(a | b);
      5'd5:  m_result = a | b;
      5'd6:  m_result = a ^ b;
      5'd7:  m_result = b << (a % W);
      5'd8:  m_result = a << (b % W);
      5'd9:  m_result = b >> (a % W);
      5'd10: m_result = a >> (b % W);
      5'd14: m_result = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd15: m_result = (a < b) ? 1 : 0;
      5'd18, 5'd19: ;
      5'd20: m_result = m_hi;
      5'd21: m_result = m_lo;
      5'd22: m_hi = a;
      5'd23: m_lo = a;
      default: m_result = '0;
    endcase
  endfunction

  function automatic void model_mdu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint q, r;
    case (op)
      5'd16: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      5'd17: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      default: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; m_dz = 1'b1;
        end else begin
          if (op == 5'd18) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q = longint'(a / b);
            r = longint'(a % b);
          end
          m_lo = q[W-1:0]; m_hi = r[W-1:0]; m_dz = 1'b0;
        end
      end
    endcase
  endfunction

  task automatic run_single(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    start = 1'b1; OP = op; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    model_single(op, a, b);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check_state(tag);
  endtask

  task automatic run_mdu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cyc = 0;
    bit busy_bad = 1'b0;
    logic [W-1:0] hi_before;
    @(negedge clk);
    start = 1'b1; OP = op; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0; In1 = $urandom; In2 = $urandom;
    if (!busy) busy_bad = 1'b1;
    hi_before = m_hi;
    while (!done && cyc < 100) begin
      if (cyc == 4) begin
        @(negedge clk);
        start = 1'b1; OP = 5'd22; In1 = ~hi_before;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!done && !busy) busy_bad = 1'b1;
    end
    model_mdu(op, a, b);
    check({tag, "_latency"}, cyc, W + 1);
    check({tag, "_busy_during"}, busy_bad, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
    check_state(tag);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    if (op == 5'd16 || op == 5'd17) run_mdu(op, a, b, tag);
    else if (op == 5'd18 || op == 5'd19) begin
`ifdef ULA_MDU_DIV_EN
      run_mdu(op, a, b, tag);
`else
      run_single(op, a, b, tag);
`endif
    end else run_single(op, a, b, tag);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return W'($urandom_range(0, 40));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    bit saw_done;
    #2 rst_n = 1'b0;
    #1;
    check_state("reset");
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_single(5'd1, 32'd5, 32'd5, "sub_eq");
    run_single(5'd14, 32'hFFFF_FFFF, 32'd1, "slt");
    run_single(5'd15, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_single(5'd7, 32'd36, 32'd1, "sll_mod");
    check("sll_mod_value", result, 32'h10);
    run_mdu(5'd16, -32'sd3, 32'd7, "mult_neg");
    check("mult_neg_lo_value", lo, 32'hFFFF_FFEB);
    run_mdu(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_hi_value", hi, 32'hFFFF_FFFE);
`ifdef ULA_MDU_DIV_EN
    run_mdu(5'd18, -32'sd7, 32'd2, "div_neg");
    check("div_neg_lo_value", lo, 32'hFFFF_FFFD);
    run_mdu(5'd19, 32'd7, 32'd0, "divu_zero");
    run_mdu(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    run_single(5'd21, 32'd0, 32'd0, "mflo_min");
    check("mflo_min_value", result, 32'h8000_0000);
`else
    run_single(5'd19, 32'd9, 32'd3, "divu_off");
`endif

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; OP = 5'd16; In1 = 32'd12345; In2 = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_result = '0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    check_state("rst_mid");
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_mid_no_done", saw_done, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'(16 + $urandom_range(0, 3));
      run_op(op, rand_opnd(), rand_opnd(), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
